// File: rtl/ahfp_pkg.sv
// Shared constants, operand struct and constant-building helpers for the
// pipelined floating-point adder/subtractor.
package ahfp_pkg;

    localparam int DEF_EXP_W  = 8;
    localparam int DEF_MAN_W  = 23;
    localparam int DEF_W      = 1 + DEF_EXP_W + DEF_MAN_W;
    localparam int DEF_BIAS   = (1 << (DEF_EXP_W - 1)) - 1;
    localparam int GRS_W      = 3;
    localparam int PIPE_DEPTH = 4;

    // Unpacked operand at the default widths: sign, biased exponent, significand with hidden bit.
    typedef struct packed {
        logic                 sign;
        logic [DEF_EXP_W-1:0] exp;
        logic [DEF_MAN_W:0]   sig;
    } ahfp_op_t;

    // Canonical quiet NaN: sign 0, exponent all-ones, mantissa MSB set.
    function automatic logic [63:0] ahfp_qnan(input int exp_w, input int man_w);
        logic [63:0] v;
        v = 64'd0;
        for (int i = 0; i < exp_w; i++) begin
            v[man_w + i] = 1'b1;
        end
        v[man_w - 1] = 1'b1;
        return v;
    endfunction

    // Largest finite magnitude: exponent all-ones minus one, mantissa all-ones.
    function automatic logic [63:0] ahfp_max_fin(input int exp_w, input int man_w);
        logic [63:0] v;
        v = 64'd0;
        for (int i = 0; i < man_w; i++) begin
            v[i] = 1'b1;
        end
        for (int i = 1; i < exp_w; i++) begin
            v[man_w + i] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/ahfp_lzc.sv
// Parametrised leading-zero counter; an all-zero input returns WIDTH.
module ahfp_lzc
    import ahfp_pkg::*;
#(
    parameter int WIDTH = DEF_MAN_W + 1 + GRS_W,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] in_vec,
    output logic [CNT_W-1:0] count
);

    logic found;

    // Scan from the MSB; counting stops at the first set bit.
    always_comb begin
        found = 1'b0;
        count = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!found && !in_vec[i]) begin
                count = count + CNT_W'(1);
            end else begin
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahfp_addsub_pipe.sv
// Four-stage floating-point adder/subtractor, truncating, denormals flushed.
// Optional macro AHFP_SPECIALS_EN enables NaN/infinity decoding and overflow-to-infinity.
module ahfp_addsub_pipe
    import ahfp_pkg::*;
#(
    parameter  int EXP_W = DEF_EXP_W,
    parameter  int MAN_W = DEF_MAN_W,
    localparam int W     = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clk_en,
    input  logic         start,
    input  logic         n,
    input  logic [W-1:0] dataa,
    input  logic [W-1:0] datab,
    output logic [W-1:0] result,
    output logic         done
);

    localparam int SIG_W     = MAN_W + 1;
    localparam int EXT_W     = SIG_W + GRS_W;
    localparam int SUM_W     = EXT_W + 1;
    localparam int CNT_W     = $clog2(EXT_W + 1);
    localparam int E_W       = EXP_W + 2;
    localparam int MAX_SHIFT = EXT_W - 1;
    localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};
    localparam logic [W-1:0]     QNAN     = W'(ahfp_qnan(EXP_W, MAN_W));
`ifdef AHFP_SPECIALS_EN
    localparam logic [W-2:0]     OVF_MAG  = {EXP_ONES, {MAN_W{1'b0}}};
`else
    localparam logic [W-2:0]     OVF_MAG  = (W-1)'(ahfp_max_fin(EXP_W, MAN_W));
`endif

    logic             sa, sb;
    logic [EXP_W-1:0] ea, eb, exp_s, diff;
    logic [MAN_W-1:0] ma, mb;
    logic [W-2:0]     mag_a, mag_b;
    logic [SIG_W-1:0] sig_a, sig_b, sig_s;
    logic [EXT_W-1:0] ext_s, shifted;
    logic             sticky;
`ifdef AHFP_SPECIALS_EN
    logic             a_nan, b_nan, a_inf, b_inf;
`endif

    logic             v1_d, sign1_d, sub1_d, nan1_d, inf1_d, isgn1_d;
    logic             v1_q, sign1_q, sub1_q, nan1_q, inf1_q, isgn1_q;
    logic [EXP_W-1:0] exp1_d, exp1_q;
    logic [EXT_W-1:0] sigl1_d, sigl1_q, sigs1_d, sigs1_q;

    logic             v2_d, sign2_d, nan2_d, inf2_d, isgn2_d;
    logic             v2_q, sign2_q, nan2_q, inf2_q, isgn2_q;
    logic [EXP_W-1:0] exp2_d, exp2_q;
    logic [SUM_W-1:0] sum2_d, sum2_q;

    logic [CNT_W-1:0] lz;
    logic [MAN_W-1:0] norm_man;
    logic             v3_d, sign3_d, zero3_d, nan3_d, inf3_d, isgn3_d;
    logic             v3_q, sign3_q, zero3_q, nan3_q, inf3_q, isgn3_q;
    logic [E_W-1:0]   exp3_d, exp3_q;
    logic [MAN_W-1:0] man3_d, man3_q;

    logic [W-1:0]     result_d, result_q;
    logic             done_d, done_q;

    // S1: unpack, flush denormals, order by magnitude and align the smaller operand.
    always_comb begin
        sa    = dataa[W-1];
        ea    = dataa[W-2 -: EXP_W];
        ma    = dataa[MAN_W-1:0];
        sb    = datab[W-1] ^ n;
        eb    = datab[W-2 -: EXP_W];
        mb    = datab[MAN_W-1:0];
        sig_a = (ea == '0) ? '0 : {1'b1, ma};
        sig_b = (eb == '0) ? '0 : {1'b1, mb};
        mag_a = (ea == '0) ? '0 : dataa[W-2:0];
        mag_b = (eb == '0) ? '0 : datab[W-2:0];
        v1_d  = start;
        sub1_d = sa ^ sb;
        if (mag_b > mag_a) begin
            sign1_d = sb;
            exp1_d  = eb;
            sigl1_d = {sig_b, {GRS_W{1'b0}}};
            exp_s   = ea;
            sig_s   = sig_a;
        end else begin
            sign1_d = sa;
            exp1_d  = ea;
            sigl1_d = {sig_a, {GRS_W{1'b0}}};
            exp_s   = eb;
            sig_s   = sig_b;
        end
        diff  = exp1_d - exp_s;
        ext_s = {sig_s, {GRS_W{1'b0}}};
        if (32'(diff) >= 32'(MAX_SHIFT)) begin
            shifted = '0;
            sticky  = |sig_s;
        end else begin
            shifted = ext_s >> diff;
            sticky  = ((shifted << diff) != ext_s);
        end
        sigs1_d = {shifted[EXT_W-1:1], shifted[0] | sticky};
`ifdef AHFP_SPECIALS_EN
        a_nan   = (ea == EXP_ONES) && (ma != '0);
        b_nan   = (eb == EXP_ONES) && (mb != '0);
        a_inf   = (ea == EXP_ONES) && (ma == '0);
        b_inf   = (eb == EXP_ONES) && (mb == '0);
        nan1_d  = a_nan | b_nan | (a_inf & b_inf & (sa != sb));
        inf1_d  = a_inf | b_inf;
        isgn1_d = a_inf ? sa : sb;
`else
        nan1_d  = 1'b0;
        inf1_d  = 1'b0;
        isgn1_d = 1'b0;
`endif
    end

    // S2: magnitude add or subtract; the larger operand is always first so no borrow-out.
    always_comb begin
        v2_d    = v1_q;
        sign2_d = sign1_q;
        exp2_d  = exp1_q;
        nan2_d  = nan1_q;
        inf2_d  = inf1_q;
        isgn2_d = isgn1_q;
        if (sub1_q) begin
            sum2_d = {1'b0, sigl1_q} - {1'b0, sigs1_q};
        end else begin
            sum2_d = {1'b0, sigl1_q} + {1'b0, sigs1_q};
        end
    end

    ahfp_lzc #(
        .WIDTH (EXT_W),
        .CNT_W (CNT_W)
    ) u_lzc (
        .in_vec (sum2_q[EXT_W-1:0]),
        .count  (lz)
    );

    // S3: normalise; guard/round/sticky fall away here because rounding truncates.
    always_comb begin
        v3_d     = v2_q;
        sign3_d  = sign2_q;
        nan3_d   = nan2_q;
        inf3_d   = inf2_q;
        isgn3_d  = isgn2_q;
        zero3_d  = 1'b0;
        exp3_d   = '0;
        man3_d   = '0;
        norm_man = MAN_W'((sum2_q[EXT_W-1:0] << lz) >> GRS_W);
        if (sum2_q == '0) begin
            zero3_d = 1'b1;
        end else if (sum2_q[SUM_W-1]) begin
            exp3_d = {2'b00, exp2_q} + E_W'(1);
            man3_d = sum2_q[SUM_W-2 -: MAN_W];
        end else if ({2'b00, exp2_q} <= E_W'(lz)) begin
            zero3_d = 1'b1;
        end else begin
            exp3_d = {2'b00, exp2_q} - E_W'(lz);
            man3_d = norm_man;
        end
    end

    // S4: pack, with specials and overflow taking priority over the normal result.
    always_comb begin
        done_d = v3_q;
        if (!v3_q) begin
            result_d = result_q;
        end else if (nan3_q) begin
            result_d = QNAN;
        end else if (inf3_q) begin
            result_d = {isgn3_q, EXP_ONES, {MAN_W{1'b0}}};
        end else if (zero3_q) begin
            result_d = '0;
        end else if (exp3_q >= E_W'(EXP_ONES)) begin
            result_d = {sign3_q, OVF_MAG};
        end else begin
            result_d = {sign3_q, exp3_q[EXP_W-1:0], man3_q};
        end
    end

    // Pipeline registers: reset clears everything, clk_en low freezes the whole pipe.
    always_ff @(posedge clk) begin
        if (reset) begin
            v1_q     <= 1'b0; sign1_q <= 1'b0; sub1_q <= 1'b0; exp1_q <= '0;
            sigl1_q  <= '0;   sigs1_q <= '0;   nan1_q <= 1'b0; inf1_q <= 1'b0; isgn1_q <= 1'b0;
            v2_q     <= 1'b0; sign2_q <= 1'b0; exp2_q <= '0;   sum2_q <= '0;
            nan2_q   <= 1'b0; inf2_q  <= 1'b0; isgn2_q <= 1'b0;
            v3_q     <= 1'b0; sign3_q <= 1'b0; zero3_q <= 1'b0; exp3_q <= '0; man3_q <= '0;
            nan3_q   <= 1'b0; inf3_q  <= 1'b0; isgn3_q <= 1'b0;
            result_q <= '0;   done_q  <= 1'b0;
        end else if (clk_en) begin
            v1_q     <= v1_d; sign1_q <= sign1_d; sub1_q <= sub1_d; exp1_q <= exp1_d;
            sigl1_q  <= sigl1_d; sigs1_q <= sigs1_d; nan1_q <= nan1_d; inf1_q <= inf1_d;
            isgn1_q  <= isgn1_d;
            v2_q     <= v2_d; sign2_q <= sign2_d; exp2_q <= exp2_d; sum2_q <= sum2_d;
            nan2_q   <= nan2_d; inf2_q <= inf2_d; isgn2_q <= isgn2_d;
            v3_q     <= v3_d; sign3_q <= sign3_d; zero3_q <= zero3_d; exp3_q <= exp3_d;
            man3_q   <= man3_d; nan3_q <= nan3_d; inf3_q <= inf3_d; isgn3_q <= isgn3_d;
            result_q <= result_d; done_q <= done_d;
        end
    end

    assign result = result_q;
    assign done   = done_q;

endmodule

// File: tb/tb_ahfp_addsub_pipe.sv
// Scoreboard bench for ahfp_addsub_pipe at default widths; honours AHFP_SPECIALS_EN.
`timescale 1ns/1ps
module tb_ahfp_addsub_pipe;
    import ahfp_pkg::*;

    localparam int WT = DEF_W;

    logic          clk    = 1'b0;
    logic          reset  = 1'b1;
    logic          clk_en = 1'b1;
    logic          start  = 1'b0;
    logic          n      = 1'b0;
    logic [WT-1:0] dataa  = '0;
    logic [WT-1:0] datab  = '0;
    logic [WT-1:0] result;
    logic          done;

    int            checks     = 0;
    int            errors     = 0;
    int            done_count = 0;
    logic [WT-1:0] sb_q[$];
    logic [WT-1:0] exp_v;
    logic [WT-1:0] one_w;

    ahfp_addsub_pipe dut (
        .clk    (clk),
        .reset  (reset),
        .clk_en (clk_en),
        .start  (start),
        .n      (n),
        .dataa  (dataa),
        .datab  (datab),
        .result (result),
        .done   (done)
    );

    always #5 clk = ~clk;

    // A done counts once, in the enabled cycle it is presented.
    always @(negedge clk) begin
        if (!reset && clk_en && done) begin
            done_count++;
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_unexpected_done result=%h required=no_done", result);
            end else begin
                exp_v = sb_q.pop_front();
                if (result !== exp_v) begin
                    errors++;
                    $display("FAIL scoreboard_result result=%h required=%h", result, exp_v);
                end
            end
        end
    end

    task automatic tick(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input logic op, input logic [WT-1:0] a, input logic [WT-1:0] b,
                         input logic [WT-1:0] r);
        start = 1'b1;
        n     = op;
        dataa = a;
        datab = b;
        sb_q.push_back(r);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic drain();
        int budget;
        budget = 20;
        while (sb_q.size() != 0 && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout pending=%0d required=0", sb_q.size());
            sb_q.delete();
        end
        tick(1);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(2);
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL reset_done done=%b required=0", done);
        end
        checks++;
        if (result !== '0) begin
            errors++;
            $display("FAIL reset_result result=%h required=00000000", result);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick(1);
    endtask

    task automatic test_latency();
        int lat;
        int highs;
        lat   = -1;
        highs = 0;
        one_w = {1'b0, 8'(DEF_BIAS), 23'd0};
        issue(1'b1, one_w, 32'h4000_0000, 32'hBF80_0000);
        for (int i = 1; i <= 8; i++) begin
            if (done === 1'b1) begin
                highs++;
                if (lat < 0) lat = i;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (lat != PIPE_DEPTH) begin
            errors++;
            $display("FAIL latency edges=%0d required=%0d", lat, PIPE_DEPTH);
        end
        checks++;
        if (highs != 1) begin
            errors++;
            $display("FAIL done_single_pulse cycles=%0d required=1", highs);
        end
        drain();
    endtask

    task automatic test_sub_align();
        issue(1'b1, 32'h43FA_0000, 32'h4113_3333, 32'h43F5_6666);
        issue(1'b1, 32'h41EC_0000, 32'h453B_F800, 32'hC53A_2000);
        issue(1'b1, 32'h4B80_0000, 32'h3F80_0000, 32'h4B7F_FFFF);
        issue(1'b1, 32'h4C00_0000, 32'h3F80_0000, 32'h4BFF_FFFF);
        issue(1'b1, 32'h4E80_0000, 32'h3F80_0000, 32'h4E7F_FFFF);
        issue(1'b0, 32'h4E80_0000, 32'h3F80_0000, 32'h4E80_0000);
        drain();
    endtask

    task automatic test_back_to_back();
        int first;
        first = -1;
        issue(1'b0, 32'h4040_0000, 32'h4060_0000, 32'h40D0_0000);
        issue(1'b0, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000);
        issue(1'b1, 32'h40A0_0000, 32'h3F80_0000, 32'h4080_0000);
        issue(1'b0, 32'h4000_0000, 32'hC040_0000, 32'hBF80_0000);
        for (int i = 0; i < 10 && first < 0; i++) begin
            if (done === 1'b1) begin
                first = i;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        checks++;
        if (first != 0) begin
            errors++;
            $display("FAIL b2b_first_done wait=%0d required=0", first);
        end
        for (int i = 1; i < 4; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (done !== 1'b1) begin
                errors++;
                $display("FAIL b2b_consecutive slot=%0d done=%b required=1", i, done);
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_tail done=%b required=0", done);
        end
        drain();
    endtask

    task automatic test_zero_flush();
        issue(1'b1, 32'h42FF_999A, 32'h42FF_999A, 32'h0000_0000);
        issue(1'b0, 32'h3F80_0000, 32'h0000_0000, 32'h3F80_0000);
        issue(1'b0, 32'h0000_0001, 32'h3F80_0000, 32'h3F80_0000);
        issue(1'b0, 32'h0040_0000, 32'h8040_0000, 32'h0000_0000);
        issue(1'b1, 32'h0080_0001, 32'h0080_0000, 32'h0000_0000);
        issue(1'b0, 32'h0080_0000, 32'h0080_0000, 32'h0100_0000);
        drain();
    endtask

    task automatic test_stall();
        issue(1'b0, 32'h4040_0000, 32'h4060_0000, 32'h40D0_0000);
        issue(1'b1, 32'h3F80_0000, 32'h4000_0000, 32'hBF80_0000);
        tick(2);
        checks++;
        if (done !== 1'b1 || result !== 32'h40D0_0000) begin
            errors++;
            $display("FAIL stall_pre done=%b result=%h required=1/40d00000", done, result);
        end
        clk_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b1 || result !== 32'h40D0_0000) begin
                errors++;
                $display("FAIL stall_frozen cycle=%0d done=%b result=%h required=1/40d00000",
                         i, done, result);
            end
            @(posedge clk);
            #1;
        end
        clk_en = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b1 || result !== 32'hBF80_0000) begin
            errors++;
            $display("FAIL stall_second done=%b result=%h required=1/bf800000", done, result);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL stall_tail done=%b required=0", done);
        end
        drain();
    endtask

    task automatic test_reset_midflight();
        int base;
        issue(1'b0, 32'h4040_0000, 32'h4060_0000, 32'h40D0_0000);
        issue(1'b0, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000);
        reset  = 1'b1;
        clk_en = 1'b0;
        @(posedge clk);
        #1;
        reset  = 1'b0;
        clk_en = 1'b1;
        sb_q.delete();
        base = done_count;
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL midreset_done done=%b required=0", done);
        end
        tick(8);
        checks++;
        if (done_count != base) begin
            errors++;
            $display("FAIL midreset_discard dones=%0d required=0", done_count - base);
        end
    endtask

    task automatic test_overflow_specials();
`ifdef AHFP_SPECIALS_EN
        issue(1'b0, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000);
        issue(1'b1, 32'hFF7F_FFFF, 32'h7F7F_FFFF, 32'hFF80_0000);
        issue(1'b1, 32'h7F80_0000, 32'h7F80_0000, 32'h7FC0_0000);
        issue(1'b0, 32'h7F80_0001, 32'h3F80_0000, 32'h7FC0_0000);
        issue(1'b0, 32'hFF80_0000, 32'h3F80_0000, 32'hFF80_0000);
`else
        issue(1'b0, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F7F_FFFF);
        issue(1'b1, 32'hFF7F_FFFF, 32'h7F7F_FFFF, 32'hFF7F_FFFF);
        issue(1'b0, 32'h7F80_0000, 32'h3F80_0000, 32'h7F7F_FFFF);
`endif
        drain();
    endtask

    initial begin
        test_reset();
        test_latency();
        test_sub_align();
        test_back_to_back();
        test_zero_flush();
        test_stall();
        test_reset_midflight();
        test_overflow_specials();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
